// File: rtl/zolpew_example_delay_line_pkg.sv
// zolpew_example_delay_line_pkg: shared sizes and data word type for the delay line
package zolpew_example_delay_line_pkg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int SEL_W = $clog2(DEPTH);
  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/zolpew_example_delay_line_delay_shift_array.sv
// zolpew_example_delay_line_delay_shift_array: enabled shift chain with async clear, all taps exported
module zolpew_example_delay_line_delay_shift_array
  import zolpew_example_delay_line_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [WIDTH-1:0]             din,
  output logic [DEPTH-1:0][WIDTH-1:0]  taps
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) taps <= '0;
    else if (ena) taps <= {taps[DEPTH-2:0], din};
endmodule

// File: rtl/zolpew_example_delay_line.sv
// zolpew_example_delay_line: 8-bit delay line of 1..32 clocks, delay chosen by uio_in[4:0]
module zolpew_example_delay_line
  import zolpew_example_delay_line_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [DEPTH-1:0][WIDTH-1:0] taps;
  logic unused_sel;
  zolpew_example_delay_line_delay_shift_array u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (ui_in),
    .taps (taps)
  );
  assign uo_out     = taps[uio_in[SEL_W-1:0]];
  assign uio_out    = '0;
  assign uio_oe     = '0;
  assign unused_sel = &uio_in[7:SEL_W];
endmodule

// File: tb/tb_zolpew_example_delay_line.sv
// tb_zolpew_example_delay_line: table vectors plus directed multi-cycle sequences
module tb_zolpew_example_delay_line;
  logic clk = 0, rst_n = 0, ena = 0;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int total = 0, bad = 0;
  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];
  zolpew_example_delay_line dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask
  task automatic add(input logic r, input logic e, input logic [7:0] u, input logic [7:0] s, input logic [7:0] x);
    vec_t v;
    v.rst = r; v.ena = e; v.ui = u; v.uio = s; v.exp = x;
    vecs.push_back(v);
  endtask
  initial begin
    int n;
    add(1, 1, 8'hA5, 8'd0, 8'hA5);
    add(0, 1, 8'h00, 8'd0, 8'h00);
    add(0, 1, 8'h00, 8'd0, 8'h00);
    add(1, 1, 8'd1, 8'd3,  8'd0);
    add(0, 1, 8'd2, 8'd3,  8'd0);
    add(0, 1, 8'd3, 8'd3,  8'd0);
    add(0, 1, 8'd4, 8'd3,  8'd1);
    add(0, 1, 8'd5, 8'hE3, 8'd2);
    add(0, 1, 8'd6, 8'd3,  8'd3);
    add(0, 1, 8'd7, 8'hE3, 8'd4);
    add(0, 1, 8'd8, 8'd3,  8'd5);
    add(0, 0, 8'd9, 8'd3,  8'd5);
    add(0, 1, 8'd9, 8'd3,  8'd6);
    ena = 1;
    ui_in = 8'($urandom);
    uio_in = 8'd5;
    #3;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    tick();
    chk("reset_held_uo", uo_out, 8'h00);
    rst_n = 1;
    foreach (vecs[i]) begin
      if (vecs[i].rst) reset_dut();
      ena = vecs[i].ena;
      ui_in = vecs[i].ui;
      uio_in = vecs[i].uio;
      tick();
      chk($sformatf("vec%0d", i), uo_out, vecs[i].exp);
    end
    for (int k = 0; k < 2; k++) begin
      reset_dut();
      ena = 1;
      uio_in = k == 0 ? 8'd31 : 8'hFF;
      for (int e = 1; e <= 34; e++) begin
        ui_in = e == 1 ? 8'h3C : 8'h00;
        tick();
        chk($sformatf("max%0d_e%0d", k, e), uo_out, e == 32 ? 8'h3C : 8'h00);
      end
    end
    reset_dut();
    uio_in = 8'd7;
    n = 0;
    for (int e = 0; e < 12; e++) begin
      ena = 1;
      n++;
      ui_in = 8'(n);
      tick();
      chk("hold_pre", uo_out, n >= 8 ? 8'(n - 7) : 8'h00);
    end
    for (int e = 0; e < 10; e++) begin
      ena = 0;
      ui_in = 8'($urandom);
      tick();
      chk("hold_frozen", uo_out, 8'd5);
    end
    for (int e = 0; e < 8; e++) begin
      ena = 1;
      n++;
      ui_in = 8'(n);
      tick();
      chk("hold_post", uo_out, 8'(n - 7));
    end
    uio_in = 8'd2;
    #1;
    chk("switch_tap", uo_out, 8'(n - 2));
    #1;
    rst_n = 0;
    #1;
    chk("async_reset", uo_out, 8'h00);
    tick();
    chk("async_reset_held", uo_out, 8'h00);
    rst_n = 1;
    n = 0;
    for (int e = 0; e < 5; e++) begin
      n++;
      ui_in = 8'(8'h40 + n);
      tick();
      chk("restart", uo_out, n >= 3 ? 8'(8'h40 + n - 2) : 8'h00);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
